ycbcr_skin_mask: RTL and testbench



---
 rtl/ycbcr_skin_mask_if.sv | 27 ++
 rtl/ycbcr_skin_mask.sv | 125 ++++++++++++
 tb/tb_ycbcr_skin_mask.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ycbcr_skin_mask_if.sv
// Pixel-stream bundle for the skin-mask stage: sync/data inputs, delayed outputs and frame statistics.
// The CNT_W here must match the CNT_W of the ycbcr_skin_mask instance it is connected to.
interface ycbcr_skin_mask_if #(
    parameter int CNT_W = 22
);
    logic             de_in;
    logic             hsync_in;
    logic             vsync_in;
    logic [23:0]      pixel_in;
    logic             de_out;
    logic             hsync_out;
    logic             vsync_out;
    logic [23:0]      pixel_out;
    logic             mask_out;
    logic [CNT_W-1:0] frame_count;
    logic             count_valid;

    modport master (
        output de_in, hsync_in, vsync_in, pixel_in,
        input  de_out, hsync_out, vsync_out, pixel_out, mask_out, frame_count, count_valid
    );

    modport slave (
        input  de_in, hsync_in, vsync_in, pixel_in,
        output de_out, hsync_out, vsync_out, pixel_out, mask_out, frame_count, count_valid
    );
endinterface

// File: rtl/ycbcr_skin_mask.sv
// RGB -> CbCr skin segmentation: 3-stage fixed-point pipeline, inclusive Cb/Cr window,
// delay-matched syncs and a per-frame mask-pixel counter gated by a primed flag.
module ycbcr_skin_mask #(
    parameter logic [7:0] CB_MIN = 8'd77,
    parameter logic [7:0] CB_MAX = 8'd127,
    parameter logic [7:0] CR_MIN = 8'd133,
    parameter logic [7:0] CR_MAX = 8'd173,
    parameter int         CNT_W  = 22
) (
    input logic            clk,
    input logic            rst_n,
    ycbcr_skin_mask_if.slave bus
);
    logic [7:0] r, g, b;
    assign r = bus.pixel_in[23:16];
    assign g = bus.pixel_in[15:8];
    assign b = bus.pixel_in[7:0];

    logic [15:0]        p_yr, p_yg, p_yb, p_cbr, p_cbg, p_cbb, p_crr, p_crg, p_crb;
    logic signed [17:0] y_s, cb_s, cr_s;
    logic               de_d1, hs_d1, vs_d1;
    logic               de_d2, hs_d2, vs_d2;

    function automatic logic signed [17:0] sx(input logic [15:0] x);
        return $signed({2'b00, x});
    endfunction

    function automatic logic [7:0] to_chroma(input logic signed [17:0] s);
        logic signed [17:0] v;
        v = (s >>> 8) + 18'sd128;
        if (v[17])
            return 8'd0;
        else if (v > 18'sd255)
            return 8'd255;
        return v[7:0];
    endfunction

    // NOTE: every register, including the arithmetic pipeline, is cleared so no stale pixel survives a reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {p_yr, p_yg, p_yb, p_cbr, p_cbg, p_cbb, p_crr, p_crg, p_crb} <= '0;
            {de_d1, hs_d1, vs_d1} <= '0;
        end else begin
            p_yr  <= 16'(r) * 16'd77;
            p_yg  <= 16'(g) * 16'd150;
            p_yb  <= 16'(b) * 16'd29;
            p_cbr <= 16'(r) * 16'd43;
            p_cbg <= 16'(g) * 16'd85;
            p_cbb <= 16'(b) * 16'd128;
            p_crr <= 16'(r) * 16'd128;
            p_crg <= 16'(g) * 16'd107;
            p_crb <= 16'(b) * 16'd21;
            {de_d1, hs_d1, vs_d1} <= {bus.de_in, bus.hsync_in, bus.vsync_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {y_s, cb_s, cr_s} <= '0;
            {de_d2, hs_d2, vs_d2} <= '0;
        end else begin
            y_s  <= sx(p_yr) + sx(p_yg) + sx(p_yb);
            cb_s <= sx(p_cbb) - sx(p_cbr) - sx(p_cbg);
            cr_s <= sx(p_crr) - sx(p_crg) - sx(p_crb);
            {de_d2, hs_d2, vs_d2} <= {de_d1, hs_d1, vs_d1};
        end
    end

    // Luma is kept in the pipeline for probing only.
    logic unused_y;
    assign unused_y = ^y_s;

    logic [7:0] cb, cr;
    logic       mask;
    always_comb begin
        cb   = to_chroma(cb_s);
        cr   = to_chroma(cr_s);
        // de_d2 gates first so undefined chroma never reaches the output during blanking.
        mask = de_d2 && (cb >= CB_MIN) && (cb <= CB_MAX) && (cr >= CR_MIN) && (cr <= CR_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.de_out    <= 1'b0;
            bus.hsync_out <= 1'b0;
            bus.vsync_out <= 1'b0;
            bus.pixel_out <= '0;
            bus.mask_out  <= 1'b0;
        end else begin
            bus.de_out    <= de_d2;
            bus.hsync_out <= hs_d2;
            bus.vsync_out <= vs_d2;
            bus.pixel_out <= {24{mask}};
            bus.mask_out  <= mask;
        end
    end

    logic [CNT_W-1:0] cnt;
    logic             vsync_prev, primed, hit;
    assign hit = bus.de_out & bus.mask_out;

    // A pixel on the vsync edge cycle belongs to the new frame; the first edge after reset only primes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt             <= '0;
            vsync_prev      <= 1'b0;
            primed          <= 1'b0;
            bus.frame_count <= '0;
            bus.count_valid <= 1'b0;
        end else begin
            vsync_prev      <= bus.vsync_out;
            bus.count_valid <= 1'b0;
            if (bus.vsync_out && !vsync_prev) begin
                primed <= 1'b1;
                cnt    <= hit ? CNT_W'(1) : '0;
                if (primed) begin
                    bus.frame_count <= cnt;
                    bus.count_valid <= 1'b1;
                end
            end else if (hit && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ycbcr_skin_mask.sv
// Scoreboarded bench: stimulus pushes expected outputs from an arithmetic colour model,
// a monitor pops them 3 cycles later and also tracks frame counts for 22-bit and 4-bit counters.
module tb_ycbcr_skin_mask;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        de = 1'b0, hs = 1'b0, vs = 1'b0;
    logic [23:0] pix = '0;

    always #5 clk = ~clk;

    ycbcr_skin_mask_if #(.CNT_W(22)) bus22 ();
    ycbcr_skin_mask_if #(.CNT_W(4))  bus4 ();

    assign bus22.de_in = de;  assign bus22.hsync_in = hs;  assign bus22.vsync_in = vs;  assign bus22.pixel_in = pix;
    assign bus4.de_in  = de;  assign bus4.hsync_in  = hs;  assign bus4.vsync_in  = vs;  assign bus4.pixel_in  = pix;

    ycbcr_skin_mask #(.CNT_W(22)) dut (.clk(clk), .rst_n(rst_n), .bus(bus22));
    ycbcr_skin_mask #(.CNT_W(4))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus4));

    localparam logic [23:0] SKIN  = {8'd224, 8'd172, 8'd140};
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREY  = 24'h808080;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;

    typedef struct {
        int due;
        bit de, hs, vs, mask;
    } exp_t;

    exp_t q[$];
    bit   rst_at[int];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int floor256(input int v);
        return (v >= 0) ? v / 256 : -((-v + 255) / 256);
    endfunction

    function automatic int clamp8(input int v);
        return (v < 0) ? 0 : (v > 255) ? 255 : v;
    endfunction

    // Reference: full-precision integer chroma, floored, offset and clamped, then window test.
    function automatic bit model_mask(input bit d, input logic [23:0] p);
        int rr, gg, bb, cbv, crv;
        rr  = int'(p[23:16]);
        gg  = int'(p[15:8]);
        bb  = int'(p[7:0]);
        cbv = clamp8(floor256(128 * bb - 43 * rr - 85 * gg) + 128);
        crv = clamp8(floor256(128 * rr - 107 * gg - 21 * bb) + 128);
        return d && cbv >= 77 && cbv <= 127 && crv >= 133 && crv <= 173;
    endfunction

    task automatic drive(input bit r, input bit d, input bit h, input bit v, input logic [23:0] p);
        exp_t e;
        int   cap;
        @(negedge clk);
        rst_n = r; de = d; hs = h; vs = v; pix = p;
        cap = cyc + 1;
        rst_at[cap] = r;
        e.due = cap + 2; e.de = d; e.hs = h; e.vs = v; e.mask = model_mask(d, p);
        q.push_back(e);
    endtask

    task automatic send_frame(input int n_skin, input int reset_line);
        int idx = 0;
        for (int y = 0; y < 64; y++) begin
            if (y == reset_line) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, BLACK);
                drive(1'b0, 1'b0, 1'b0, 1'b0, BLACK);
            end
            for (int x = 0; x < 64; x++) begin
                drive(1'b1, 1'b1, 1'b0, 1'b0, (idx < n_skin) ? SKIN : BLACK);
                idx++;
            end
            for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, i < 2, 1'b0, BLACK);
        end
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b1, BLACK);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, BLACK);
    endtask

    // Monitor: output alignment plus a frame-level counting model fed by the expected outputs.
    initial begin
        exp_t e;
        bit   live, cv, hit;
        bit   p_de = 0, p_vs = 0, p_mask = 0;
        bit   m_prev = 0, m_primed = 0;
        int   m_cnt = 0, m_fc = 0, k;
        forever begin
            @(posedge clk);
            #1;
            k = cyc;
            if (q.size() == 0) continue;
            if (q[0].due < k) begin
                check("sb_due", q[0].due, k);
                void'(q.pop_front());
                continue;
            end
            if (q[0].due > k) continue;
            e    = q.pop_front();
            live = rst_at[k - 2] && rst_at[k - 1] && rst_at[k];
            if (!live) begin
                e.de = 0; e.hs = 0; e.vs = 0; e.mask = 0;
            end
            check("de_out", bus22.de_out, e.de);
            check("hsync_out", bus22.hsync_out, e.hs);
            check("vsync_out", bus22.vsync_out, e.vs);
            check("mask_out", bus22.mask_out, e.mask);
            check("pixel_out", bus22.pixel_out, {24{e.mask}});
            check("sat_mask_out", bus4.mask_out, e.mask);

            cv = 0;
            if (!rst_at[k]) begin
                m_cnt = 0; m_fc = 0; m_prev = 0; m_primed = 0;
            end else begin
                hit = p_de && p_mask;
                if (p_vs && !m_prev) begin
                    if (m_primed) begin
                        m_fc = m_cnt;
                        cv   = 1;
                    end
                    m_primed = 1;
                    m_cnt    = hit ? 1 : 0;
                end else begin
                    m_cnt += hit ? 1 : 0;
                end
                m_prev = p_vs;
            end
            check("count_valid", bus22.count_valid, cv);
            check("frame_count", bus22.frame_count, (m_fc > 4194303) ? 4194303 : m_fc);
            check("sat_count_valid", bus4.count_valid, cv);
            check("sat_frame_count", 32'(bus4.frame_count), (m_fc > 15) ? 15 : m_fc);
            p_de = e.de; p_vs = e.vs; p_mask = e.mask;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, BLACK);

        // Directed colours, then skin-valued pixels with de low.
        drive(1'b1, 1'b1, 1'b0, 1'b0, SKIN);
        drive(1'b1, 1'b1, 1'b0, 1'b0, RED);
        drive(1'b1, 1'b1, 1'b0, 1'b0, GREY);
        drive(1'b1, 1'b1, 1'b0, 1'b0, WHITE);
        drive(1'b1, 1'b1, 1'b0, 1'b0, BLACK);
        drive(1'b1, 1'b1, 1'b1, 1'b0, SKIN);
        drive(1'b1, 1'b0, 1'b0, 1'b0, SKIN);
        drive(1'b1, 1'b0, 1'b1, 1'b1, SKIN);
        drive(1'b1, 1'b1, 1'b0, 1'b0, SKIN);

        // Random syncs and colours biased toward the skin region.
        for (int i = 0; i < 600; i++) begin
            logic [23:0] p;
            if ($urandom_range(1, 0) == 1)
                p = {8'($urandom_range(255, 150)), 8'($urandom_range(200, 90)), 8'($urandom_range(180, 70))};
            else
                p = 24'($urandom);
            drive(1'b1, $urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0, $urandom_range(15, 0) == 0, p);
        end

        // Frame sequence: prime, report 100, report 0, mid-frame reset, report 20 (15 when saturated).
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, BLACK);
        send_frame(100, -1);
        send_frame(100, -1);
        send_frame(0, -1);
        send_frame(100, 30);
        send_frame(20, -1);
        send_frame(0, -1);

        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, BLACK);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        check("sb_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
